// File: rtl/idex_hazard_ctrl_if.sv
// Signal bundle between the decode/ID-EX/EX stages and the ID/EX hazard controller.
// The master side drives operand/ID-EX observations and receives stall/flush controls.
interface idex_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        idex_mem_read;
  logic [4:0]  idex_rt;
  logic        idex_md_start;
  logic        branch_taken;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        idex_hold;
  logic        ifid_flush;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs, id_rt, idex_mem_read, idex_rt, idex_md_start, branch_taken,
    input  pc_write, ifid_write, idex_bubble, idex_hold, ifid_flush, md_busy, md_done,
           stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, idex_mem_read, idex_rt, idex_md_start, branch_taken,
    output pc_write, ifid_write, idex_bubble, idex_hold, ifid_flush, md_busy, md_done,
           stall_cycles
  );
endinterface

// File: rtl/idex_hazard_ctrl.sv
// ID/EX hazard controller: load-use interlock, branch flush and multi-cycle mul/div hold.
// Optional macro IDEX_STALL_COUNTER_EN builds a 32-bit stall-cycle performance counter.
module idex_hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 8,
  parameter int          CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  idex_hazard_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] md_cnt_next;

  logic pc_write;
  logic ifid_write;
  logic idex_bubble;
  logic idex_hold;
  logic ifid_flush;
  logic md_busy;
  logic md_done;
  logic load_use;

  assign load_use = bus.idex_mem_read && (bus.idex_rt != 5'd0) &&
                    ((bus.idex_rt == bus.id_rs) || (bus.idex_rt == bus.id_rt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      md_cnt <= '0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
    end
  end

  // The issue cycle counts as the first stall cycle, so the counter is loaded with MD_CYCLES-2.
  always_comb begin
    state_next  = state;
    md_cnt_next = md_cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    idex_hold   = 1'b0;
    ifid_flush  = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;

    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (bus.idex_md_start) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_hold   = 1'b1;
            md_busy     = 1'b1;
            state_next  = MD_BUSY;
            md_cnt_next = CNT_W'(MD_CYCLES - 2);
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        MD_BUSY: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_hold  = 1'b1;
          md_busy    = 1'b1;
          if (md_cnt != '0) begin
            md_cnt_next = md_cnt - CNT_W'(1);
          end else begin
            md_done    = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.idex_bubble = idex_bubble;
  assign bus.idex_hold   = idex_hold;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.md_busy     = md_busy;
  assign bus.md_done     = md_done;

`ifdef IDEX_STALL_COUNTER_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!pc_write) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
`else
  assign bus.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Self-checking bench for idex_hazard_ctrl: directed scenarios followed by randomized
// traffic, compared against a remaining-stall-cycles reference model.
module tb_idex_hazard_ctrl;

  localparam int MD_CYCLES = 8;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  idex_hazard_ctrl_if bus ();

  idex_hazard_ctrl #(
    .MD_CYCLES (MD_CYCLES),
    .CNT_W     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a mul/div is just a count of stall cycles still owed after issue.
  int          md_left;
  logic [31:0] exp_stall;
  logic exp_pc, exp_ifid, exp_bubble, exp_hold, exp_flush, exp_busy, exp_done;

  task automatic modelEval();
    logic lu;
    exp_pc = 1'b1; exp_ifid = 1'b1; exp_bubble = 1'b0; exp_hold = 1'b0;
    exp_flush = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    lu = bus.idex_mem_read && (bus.idex_rt != 5'd0) &&
         (bus.idex_rt == bus.id_rs || bus.idex_rt == bus.id_rt);
    if (!rst_n) begin
      exp_pc = 1'b0; exp_ifid = 1'b0; exp_bubble = 1'b1;
    end else if (md_left > 0) begin
      exp_pc = 1'b0; exp_ifid = 1'b0; exp_hold = 1'b1; exp_busy = 1'b1;
      exp_done = (md_left == 1);
    end else if (bus.branch_taken) begin
      exp_flush = 1'b1; exp_bubble = 1'b1;
    end else if (bus.idex_md_start) begin
      exp_pc = 1'b0; exp_ifid = 1'b0; exp_hold = 1'b1; exp_busy = 1'b1;
    end else if (lu) begin
      exp_pc = 1'b0; exp_ifid = 1'b0; exp_bubble = 1'b1;
    end
  endtask

  task automatic modelAdvance();
    if (rst_n) begin
`ifdef IDEX_STALL_COUNTER_EN
      if (!exp_pc) exp_stall = exp_stall + 32'd1;
`endif
      if (md_left > 0) md_left = md_left - 1;
      else if (!bus.branch_taken && bus.idex_md_start) md_left = MD_CYCLES - 1;
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    modelEval();
    checkBit({tag, ".pc_write"},    bus.pc_write,    exp_pc);
    checkBit({tag, ".ifid_write"},  bus.ifid_write,  exp_ifid);
    checkBit({tag, ".idex_bubble"}, bus.idex_bubble, exp_bubble);
    checkBit({tag, ".idex_hold"},   bus.idex_hold,   exp_hold);
    checkBit({tag, ".ifid_flush"},  bus.ifid_flush,  exp_flush);
    checkBit({tag, ".md_busy"},     bus.md_busy,     exp_busy);
    checkBit({tag, ".md_done"},     bus.md_done,     exp_done);
    tests_run++;
    assert (bus.stall_cycles === exp_stall) else begin
      tests_failed++;
      $error("[TB] FAIL %s.stall_cycles observed=%0d expected=%0d at %0t",
             tag, bus.stall_cycles, exp_stall, $time);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, check mid-cycle, then advance the model.
  task automatic applyStimulus(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                               input logic mr, input logic [4:0] irt,
                               input logic ms, input logic br);
    @(negedge clk);
    bus.id_rs = rs; bus.id_rt = rt; bus.idex_mem_read = mr;
    bus.idex_rt = irt; bus.idex_md_start = ms; bus.branch_taken = br;
    #1;
    checkOutput(tag);
    @(posedge clk);
    modelAdvance();
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.idex_mem_read = 1'b0;
    bus.idex_rt = 5'd0; bus.idex_md_start = 1'b0; bus.branch_taken = 1'b0;
    rst_n = 1'b0;
    md_left = 0; exp_stall = 32'd0;
    #1;
    checkOutput("reset");
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_total;
    tests_run = 0; tests_failed = 0;
    md_left = 0; exp_stall = 32'd0;
    rst_n = 1'b1;
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.idex_mem_read = 1'b0;
    bus.idex_rt = 5'd0; bus.idex_md_start = 1'b0; bus.branch_taken = 1'b0;

    doReset(3);
    applyStimulus("idle", 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);

    // Mul/div then load-use from a clean reset: exactly MD_CYCLES+1 stalled edges.
    for (int i = 0; i < MD_CYCLES; i++)
      applyStimulus("md", 5'd0, 5'd0, 1'b0, 5'd0, (i == 0), 1'b0);
    applyStimulus("md_after", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    applyStimulus("lu_rs", 5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0);
    applyStimulus("lu_release", 5'd5, 5'd9, 1'b0, 5'd5, 1'b0, 1'b0);
    @(negedge clk);
`ifdef IDEX_STALL_COUNTER_EN
    exp_total = 32'(MD_CYCLES + 1);
`else
    exp_total = 32'd0;
`endif
    tests_run++;
    assert (bus.stall_cycles === exp_total) else begin
      tests_failed++;
      $error("[TB] FAIL stall_total observed=%0d expected=%0d", bus.stall_cycles, exp_total);
    end

    applyStimulus("lu_rt", 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
    applyStimulus("lu_r0", 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    applyStimulus("lu_nomem", 5'd4, 5'd4, 1'b0, 5'd4, 1'b0, 1'b0);
    applyStimulus("priority", 5'd6, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1);
    applyStimulus("priority_after", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Branch asserted during a mul/div must be ignored; then abort by reset three cycles in.
    applyStimulus("abort_issue", 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    applyStimulus("abort_b1", 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1);
    applyStimulus("abort_b2", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    md_left = 0; exp_stall = 32'd0;
    #1;
    checkOutput("abort_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("abort_idle", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Randomized traffic with a small register range so load-use matches are frequent.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
